// File: rtl/winograd_hadamard_accum.sv
// winograd_hadamard_accum
// Hadamard (element-wise) multiply-accumulate stage of the Winograd F(4,3)
// datapath. Forms M = U (.) V for a 6x6 tile, one row of six products per
// cycle. The result can either replace M or be added to it, which
// accumulates over input channels.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a tile operation (sampled only while idle)
//   acc_clear  sampled with start: 1 -> M = U(.)V, 0 -> M = M + U(.)V
//   u_in       6x6 transformed kernel; row r is read one cycle after row r-1
//   v_in       6x6 transformed input tile; same read schedule as u_in
//   m_out      6x6 registered accumulator / result
//   busy       high whenever the FSM is not idle
//   done       registered one-cycle completion pulse
//   state_o    current FSM state, for debug and checkers
//
// Handshake: start is a level sampled on a rising edge while idle. It is
// not acknowledged and is ignored while busy. u_in/v_in must be held
// from the accepting edge until the last row has been written.
//
// Build option: define WINOGRAD_HADAMARD_SAT_EN to saturate the product
// and the accumulation to the signed DATA_W range. Without it, the product
// is truncated and the sum wraps.
module winograd_hadamard_accum #(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          acc_clear,
  input  logic [0:5][0:5][DATA_W-1:0]   u_in,
  input  logic [0:5][0:5][DATA_W-1:0]   v_in,
  output logic [0:5][0:5][DATA_W-1:0]   m_out,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    row_q, row_d;
  logic                          clr_q, clr_d;
  logic                          done_q, done_d;
  logic [0:5][0:5][DATA_W-1:0]   m_q, m_d;

`ifdef WINOGRAD_HADAMARD_SAT_EN
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] mac(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] acc,
                                            input logic              clr);
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          p;
    logic [DATA_W:0]            s;
    prod = $signed(a) * $signed(b);
    // Product fits in DATA_W bits only if the top DATA_W+1 bits agree.
    if ((&prod[2*DATA_W-1:DATA_W-1]) || (~|prod[2*DATA_W-1:DATA_W-1]))
      p = prod[DATA_W-1:0];
    else
      p = prod[2*DATA_W-1] ? MIN_V : MAX_V;
    // One guard bit: overflow shows up as guard bit != sign bit.
    s = {acc[DATA_W-1], acc} + {p[DATA_W-1], p};
    if (clr)
      return p;
    else if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? MIN_V : MAX_V;
    else
      return s[DATA_W-1:0];
  endfunction
`else
  function automatic logic [DATA_W-1:0] mac(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] acc,
                                            input logic              clr);
    logic [DATA_W-1:0] p;
    // The low DATA_W bits of a two's complement product do not depend on
    // signedness, so a DATA_W-wide multiply is the truncated product.
    p = a * b;
    return clr ? p : acc + p;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        row_d = 3'd0;
        if (start) begin
          clr_d   = acc_clear;
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        for (int c = 0; c < 6; c++) begin
          m_d[row_q][c] = mac(u_in[row_q][c], v_in[row_q][c], m_q[row_q][c], clr_q);
        end
        if (row_q == 3'd5) begin
          row_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        row_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      m_q     <= m_d;
    end
  end

  assign m_out   = m_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_winograd_hadamard_accum.sv
// Directed bench for winograd_hadamard_accum (DATA_W = 32).
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_winograd_hadamard_accum;

  localparam int W = 32;
  typedef logic [0:5][0:5][W-1:0] mat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, acc_clear;
  mat_t       u_in, v_in, m_out;
  logic       busy, done;
  logic [1:0] state_o;

  winograd_hadamard_accum #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_clear(acc_clear),
    .u_in(u_in), .v_in(v_in), .m_out(m_out),
    .busy(busy), .done(done), .state_o(state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  mat_t exp_m;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic chk_m(input string tag);
    int fr, fc;
    fr = 0; fc = 0;
    for (int r = 5; r >= 0; r--)
      for (int c = 5; c >= 0; c--)
        if (m_out[r][c] !== exp_m[r][c]) begin fr = r; fc = c; end
    n_checks++;
    assert (m_out === exp_m) n_pass++;
    else $error("FAIL %s: m_out[%0d][%0d] observed %h expected %h",
                tag, fr, fc, m_out[fr][fc], exp_m[fr][fc]);
  endtask

  task automatic fill(output mat_t m, input logic [W-1:0] val);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) m[r][c] = val;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Starts an operation from an idle cycle. busy_pulse_at: cycle after
  // which start is re-raised for one edge (acc_clear=0) while busy.
  // v5_zero_at: cycle after which v_in row 5 is forced to 0.
  // Returns after the cycle where done is high (no extra edge consumed).
  task automatic run_op(input string tag, input logic clr,
                        input int busy_pulse_at, input int v5_zero_at);
    int n;
    start = 1'b1; acc_clear = clr;
    tick;                       // E0
    start = 1'b0; acc_clear = 1'b0;
    chk({tag, " busy after E0"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (n < 20) begin
      if (n == busy_pulse_at) begin start = 1'b1; acc_clear = 1'b0; end
      if (n == v5_zero_at)
        for (int c = 0; c < 6; c++) v_in[5][c] = '0;
      tick;
      n++;
      start = 1'b0;
      if (done) break;
    end
    chk({tag, " latency"}, n, 32'd7);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; acc_clear = 1'b0;
    u_in = '0; v_in = '0;
    #12;
    fill(exp_m, 32'd0);
    chk_m("reset m_out");
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single tile with clear: U[i][j] = 6i+j, V = 3
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        u_in[r][c] = 6*r + c;
        v_in[r][c] = 3;
        exp_m[r][c] = 3*(6*r + c);
      end
    run_op("single", 1'b1, -1, -1);
    chk_m("single m_out");
    tick;
    chk("single done width", {31'd0, done}, 32'd0);
    chk("single busy after", {31'd0, busy}, 32'd0);

    // Three channels back-to-back: U=5, V=-2 -> -10 each
    fill(u_in, 32'd5);
    fill(v_in, -32'sd2);
    run_op("acc1", 1'b1, -1, -1);
    fill(exp_m, -32'sd10);
    chk_m("acc1 m_out");
    run_op("acc2", 1'b0, -1, -1);     // start raised in the done cycle
    fill(exp_m, -32'sd20);
    chk_m("acc2 m_out");
    run_op("acc3", 1'b0, -1, -1);
    fill(exp_m, -32'sd30);
    chk_m("acc3 m_out");
    tick;

    // Start while busy: pulse sampled at E3 with acc_clear=0 is ignored
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        u_in[r][c] = 6*r + c;
        v_in[r][c] = 3;
        exp_m[r][c] = 3*(6*r + c);
      end
    run_op("busy_start", 1'b1, 2, -1);
    chk_m("busy_start m_out");
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("busy_start no second op", {30'd0, busy, done}, 32'd0);
    end

    // Overflow behaviour
    fill(u_in, 32'h7FFF_FFFF);
    fill(v_in, 32'd2);
    run_op("ovf_clr", 1'b1, -1, -1);
`ifdef WINOGRAD_HADAMARD_SAT_EN
    fill(exp_m, 32'h7FFF_FFFF);
`else
    fill(exp_m, 32'hFFFF_FFFE);
`endif
    chk_m("ovf_clr m_out");
    tick;
    fill(u_in, 32'd1);
    fill(v_in, 32'd1);
    run_op("ovf_acc", 1'b0, -1, -1);
`ifdef WINOGRAD_HADAMARD_SAT_EN
    fill(exp_m, 32'h7FFF_FFFF);
`else
    fill(exp_m, 32'hFFFF_FFFF);
`endif
    chk_m("ovf_acc m_out");
    tick;

    // Row ordering: V=7, row 5 of V zeroed after E3; U=1
    fill(u_in, 32'd1);
    fill(v_in, 32'd7);
    run_op("rows", 1'b1, 3, 3);
    fill(exp_m, 32'd7);
    for (int c = 0; c < 6; c++) exp_m[5][c] = '0;
    chk_m("rows m_out");
    tick;

    // Reset mid-operation after E3, then a fresh clear op with U=V=2
    fill(u_in, 32'd9);
    fill(v_in, 32'd9);
    start = 1'b1; acc_clear = 1'b1;
    tick;                       // E0
    start = 1'b0;
    tick; tick; tick;           // E1..E3
    exp_m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++) exp_m[r][c] = 32'd81;
    exp_m[3] = m_out[3];        // row 3 untouched yet; compare rows 0..2 only
    exp_m[4] = m_out[4];
    exp_m[5] = m_out[5];
    chk("partial row0", m_out[0][0], 32'd81);
    chk("partial row3 kept", m_out[3][0], 32'd7);
    rst_n = 1'b0;
    #1;
    fill(exp_m, 32'd0);
    chk_m("midreset m_out");
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    fill(u_in, 32'd2);
    fill(v_in, 32'd2);
    run_op("after_reset", 1'b1, -1, -1);
    fill(exp_m, 32'd4);
    chk_m("after_reset m_out");
    tick;
    chk("after_reset done width", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/winograd_hadamard_accum.md
# winograd_hadamard_accum

Element-wise (Hadamard) multiply-accumulate stage of the Winograd F(4,3) datapath. Consumes the 6x6 transformed kernel U from the kernel transform unit and a 6x6 transformed input tile V, and forms M = U ⊙ V, optionally accumulated over input channels. Processes one row of six products per cycle. Its 6x6 result feeds the output transform stage.

## Interface
- DATA_W, 32: element width, signed two's complement, for U, V and M.

- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one tile operation; sampled only in S_IDLE, ignored otherwise.
- acc_clear  input  1  sampled with start: 1 → M = U⊙V; 0 → M = M + U⊙V.
- u_in  input  [0:5][0:5] x DATA_W  transformed kernel (from kernel transform unit output).
- v_in  input  [0:5][0:5] x DATA_W  transformed input tile.
- m_out  output  [0:5][0:5] x DATA_W  registered accumulator / result.
- busy  output  1  high whenever state ≠ S_IDLE.
- done  output  1  registered, one-cycle pulse on completion.

## Operation
- States: S_IDLE → S_ROW → S_DONE → S_IDLE.
- S_IDLE: done <= 0, row <= 0; on start, latch acc_clear into clr_q, go to S_ROW.
- S_ROW: for c in 0..5, p = u_in[row][c] * v_in[row][c] (full 2*DATA_W signed product, then reduced); m_out[row][c] <= clr_q ? p : m_out[row][c] + p. row increments; at row == 5, row <= 0, go to S_DONE.
- S_DONE: done <= 1, go to S_IDLE.
- Default arithmetic: product truncated to low DATA_W bits; addition wraps modulo 2^DATA_W.
- Rows not yet processed keep their previous m_out values during S_ROW.
- m_out is never cleared except by reset or by an operation with acc_clear = 1.
- Illegal state encoding → S_IDLE.
- Reset (any time, including mid-operation): state = S_IDLE, row = 0, clr_q = 0, done = 0, busy = 0, every m_out element = 0; partial results discarded.

## Timing
- Edge E0: start sampled high in S_IDLE → S_ROW.
- Edges E1..E6: rows 0..5 of m_out written (row r at E(r+1)); E6 moves to S_DONE.
- Edge E7: done <= 1, state → S_IDLE; done high for exactly the cycle after E7; m_out final and stable from E6.
- Latency: 7 cycles start-to-done; throughput one tile per 8 cycles (start may be asserted in the cycle done is high, which is S_IDLE).
- u_in/v_in must be held stable from E0 through E6; row r is read only at E(r+1). acc_clear only matters at E0.
- start while busy: ignored, no effect on state, counters or clr_q.
- busy is combinational from state: high from after E0 until after E7.

## Configuration
- WINOGRAD_HADAMARD_SAT_EN defined: product saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before use; accumulate sum also saturated to that range on signed overflow. Timing unchanged.
- Not defined: truncation/wrap arithmetic as in Operation.

## Test plan
- Reset mid-operation: assert rst_n low after E3 → m_out all 0, busy 0, done 0 immediately; next start with acc_clear=1, U=V=all 2 → all m_out = 4, done pulse at E7.
- Single tile clear: U[i][j]=i*6+j, V all 3, acc_clear=1 → m_out[i][j]=3*(i*6+j); done exactly one cycle, 7 edges after start.
- Accumulate 3 channels: U all 5, V all -2, first acc_clear=1 then two acc_clear=0 → all m_out = -30; back-to-back starts in done cycle accepted.
- Start while busy: pulse start at E3 with acc_clear=0 → ignored, single done pulse, result equals single-tile result.
- Overflow: U all 0x7FFF_FFFF, V all 2, acc_clear=1 → without macro m_out = 0xFFFF_FFFE; with WINOGRAD_HADAMARD_SAT_EN m_out = 0x7FFF_FFFF; then accumulate U=V=all 1 → without macro 0xFFFF_FFFF, with macro stays 0x7FFF_FFFF.
- Row ordering: change v_in row 5 to 0 between E3 and E5 → rows 0..4 use old V, row 5 = 0 (confirms per-row sampling).
